// File: rtl/mem_stage_pkg.sv
// Shared types and helpers for the memory stage: FSM state, access-size codes,
// byte-strobe generation and load extension.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Helpers work on the widest supported word; callers slice down to DATA_W.
    localparam int unsigned MAX_BYTES  = 16;
    localparam int unsigned MAX_DATA_W = MAX_BYTES * 8;

    typedef logic [3:0]            byteOff_t;
    typedef logic [MAX_BYTES-1:0]  strobe_t;
    typedef logic [MAX_DATA_W-1:0] wideWord_t;

    function automatic int unsigned sizeBytes(input logic [1:0] size,
                                              input int unsigned wordBytes);
        case (size)
            SZ_BYTE: return 1;
            SZ_HALF: return 2;
            default: return wordBytes;
        endcase
    endfunction

    function automatic logic isMisaligned(input logic [1:0] size,
                                          input byteOff_t off);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return off[0];
            default: return off != '0;
        endcase
    endfunction

    function automatic strobe_t makeStrobe(input logic [1:0] size,
                                           input byteOff_t off,
                                           input int unsigned wordBytes);
        strobe_t     strb  = '0;
        int unsigned first = 32'(off);
        int unsigned last  = first + sizeBytes(size, wordBytes);
        for (int unsigned i = 0; i < MAX_BYTES; i++) begin
            strb[i] = (i >= first) && (i < last);
        end
        return strb;
    endfunction

    // raw is already shifted so the addressed byte sits in bits [7:0].
    function automatic wideWord_t extendLoad(input wideWord_t raw,
                                             input logic [1:0] size,
                                             input logic isUnsigned);
        case (size)
            SZ_BYTE: return {{(MAX_DATA_W-8){~isUnsigned & raw[7]}}, raw[7:0]};
            SZ_HALF: return {{(MAX_DATA_W-16){~isUnsigned & raw[15]}}, raw[15:0]};
            default: return raw;
        endcase
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Direct-mapped tag/valid/data storage: whole-line fill port, byte-strobed word
// write port, combinational read of the indexed line.
module dcache_array
    import mem_stage_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 4,
    parameter int SETS       = 16,
    parameter int TAG_W      = 24
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [$clog2(SETS)-1:0]      index,
    input  logic [$clog2(LINE_WORDS)-1:0] wordSel,
    output logic                         rdValid,
    output logic [TAG_W-1:0]             rdTag,
    output logic [DATA_W-1:0]            rdWord,
    input  logic                         fillEn,
    input  logic [TAG_W-1:0]             fillTag,
    input  logic [LINE_WORDS*DATA_W-1:0] fillLine,
    input  logic                         wrEn,
    input  logic [DATA_W-1:0]            wrData,
    input  logic [DATA_W/8-1:0]          wrStrb
);

    logic [SETS-1:0]   validBits;
    logic [TAG_W-1:0]  tagMem  [SETS];
    logic [DATA_W-1:0] dataMem [SETS][LINE_WORDS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            validBits <= '0;
        end else if (fillEn) begin
            validBits[index] <= 1'b1;
        end
    end

    // NOTE: tag and data arrays are not reset; the valid bits alone make stale contents unreachable.
    always_ff @(posedge clk) begin
        if (fillEn) begin
            tagMem[index] <= fillTag;
            for (int w = 0; w < LINE_WORDS; w++) begin
                dataMem[index][w] <= fillLine[w*DATA_W +: DATA_W];
            end
        end else if (wrEn) begin
            for (int b = 0; b < DATA_W/8; b++) begin
                if (wrStrb[b]) begin
                    dataMem[index][wordSel][b*8 +: 8] <= wrData[b*8 +: 8];
                end
            end
        end
    end

    assign rdValid = validBits[index];
    assign rdTag   = tagMem[index];
    assign rdWord  = dataMem[index][wordSel];

endmodule

// File: rtl/mem_stage_ctrl.sv
// Pipeline memory stage: write-through, no-write-allocate direct-mapped cache
// with a stalling miss/write controller and a handshaked line-fill RAM port.
module mem_stage_ctrl
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 4,
    parameter int SETS       = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_mem_read,
    input  logic                         i_mem_write,
    input  logic [1:0]                   i_size,
    input  logic                         i_unsigned,
    input  logic                         i_branch,
    input  logic                         i_alu_zero,
    input  logic [ADDR_W-1:0]            i_alu_result,
    input  logic [DATA_W-1:0]            i_wdata,
    output logic [DATA_W-1:0]            o_rdata,
    output logic [ADDR_W-1:0]            o_alu_result,
    output logic                         o_pc_src,
    output logic                         o_stall,
    output logic                         o_hit,
    output logic                         o_misalign,
    output logic                         o_ram_req,
    output logic                         o_ram_we,
    output logic [ADDR_W-1:0]            o_ram_addr,
    output logic [DATA_W-1:0]            o_ram_wdata,
    output logic [DATA_W/8-1:0]          o_ram_wstrb,
    input  logic                         i_ram_ready,
    input  logic [LINE_WORDS*DATA_W-1:0] i_ram_rline
);

    localparam int unsigned WORD_BYTES = DATA_W / 8;
    localparam int OFF_W  = $clog2(DATA_W / 8);
    localparam int WSEL_W = $clog2(LINE_WORDS);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - OFF_W - WSEL_W - IDX_W;

    state_t state, nextState;

    logic [OFF_W-1:0]  offset;
    logic [WSEL_W-1:0] wordSel;
    logic [IDX_W-1:0]  index;
    logic [TAG_W-1:0]  tag;

    assign offset  = i_alu_result[OFF_W-1:0];
    assign wordSel = i_alu_result[OFF_W +: WSEL_W];
    assign index   = i_alu_result[OFF_W+WSEL_W +: IDX_W];
    assign tag     = i_alu_result[ADDR_W-1 -: TAG_W];

    logic             arrValid;
    logic [TAG_W-1:0] arrTag;
    logic [DATA_W-1:0] arrWord;
    logic             lineHit;
    logic             misalign;
    logic             anyReq;
    strobe_t          strobeWide;
    logic [DATA_W/8-1:0] strobe;
    logic [DATA_W-1:0] laneData;
    logic [DATA_W-1:0] laneMasked;

    assign anyReq     = i_mem_read | i_mem_write;
    assign misalign   = anyReq & isMisaligned(i_size, byteOff_t'(offset));
    assign lineHit    = arrValid && (arrTag == tag);
    assign strobeWide = makeStrobe(i_size, byteOff_t'(offset), WORD_BYTES);
    assign strobe     = strobeWide[DATA_W/8-1:0];
    assign laneData   = i_wdata << {offset, 3'b000};

    always_comb begin
        for (int b = 0; b < DATA_W/8; b++) begin
            laneMasked[b*8 +: 8] = strobe[b] ? laneData[b*8 +: 8] : 8'h00;
        end
    end

    dcache_array #(
        .DATA_W     (DATA_W),
        .LINE_WORDS (LINE_WORDS),
        .SETS       (SETS),
        .TAG_W      (TAG_W)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .index    (index),
        .wordSel  (wordSel),
        .rdValid  (arrValid),
        .rdTag    (arrTag),
        .rdWord   (arrWord),
        .fillEn   (state == FILL && i_ram_ready),
        .fillTag  (tag),
        .fillLine (i_ram_rline),
        .wrEn     (state == WRITE && i_ram_ready && lineHit),
        .wrData   (laneMasked),
        .wrStrb   (strobe)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (!misalign) begin
                    if (i_mem_write) begin
                        nextState = WRITE;
                    end else if (i_mem_read && !lineHit) begin
                        nextState = FILL;
                    end
                end
            end
            FILL, WRITE: begin
                if (i_ram_ready) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        o_stall     = 1'b0;
        o_hit       = 1'b0;
        o_ram_req   = 1'b0;
        o_ram_we    = 1'b0;
        o_ram_wstrb = '0;
        o_ram_wdata = '0;
        case (state)
            IDLE: begin
                if (!misalign) begin
                    if (i_mem_write) begin
                        o_stall = 1'b1;
                    end else if (i_mem_read) begin
                        o_hit   = lineHit;
                        o_stall = ~lineHit;
                    end
                end
            end
            FILL: begin
                o_ram_req = 1'b1;
                o_stall   = 1'b1;
            end
            WRITE: begin
                o_ram_req   = 1'b1;
                o_ram_we    = 1'b1;
                o_stall     = ~i_ram_ready;
                o_ram_wstrb = strobe;
                o_ram_wdata = laneMasked;
            end
            default: ;
        endcase
    end

    // Fills fetch the whole line; writes go out word-aligned with lane strobes.
    always_comb begin
        if (state == FILL) begin
            o_ram_addr = {i_alu_result[ADDR_W-1:OFF_W+WSEL_W], {(OFF_W+WSEL_W){1'b0}}};
        end else begin
            o_ram_addr = {i_alu_result[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        end
    end

    wideWord_t loadRaw;
    wideWord_t loadExt;

    always_comb begin
        loadRaw              = '0;
        loadRaw[DATA_W-1:0]  = arrWord >> {offset, 3'b000};
        loadExt              = extendLoad(loadRaw, i_size, i_unsigned);
    end

    assign o_rdata      = loadExt[DATA_W-1:0];
    assign o_misalign   = misalign;
    assign o_alu_result = i_alu_result;
    assign o_pc_src     = i_branch & i_alu_zero & ~o_stall;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: fills, hits, sub-word stores/loads,
// no-allocate store miss, misalignment and reset during a fill.
module tb_mem_stage_ctrl;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int LINE_WORDS = 4;
    localparam int SETS       = 16;

    logic                         clk = 1'b0;
    logic                         rst;
    logic                         i_mem_read, i_mem_write, i_unsigned;
    logic [1:0]                   i_size;
    logic                         i_branch, i_alu_zero;
    logic [ADDR_W-1:0]            i_alu_result;
    logic [DATA_W-1:0]            i_wdata;
    logic [DATA_W-1:0]            o_rdata;
    logic [ADDR_W-1:0]            o_alu_result;
    logic                         o_pc_src, o_stall, o_hit, o_misalign;
    logic                         o_ram_req, o_ram_we;
    logic [ADDR_W-1:0]            o_ram_addr;
    logic [DATA_W-1:0]            o_ram_wdata;
    logic [DATA_W/8-1:0]          o_ram_wstrb;
    logic                         i_ram_ready;
    logic [LINE_WORDS*DATA_W-1:0] i_ram_rline;

    int nChecks = 0;
    int nFails  = 0;

    mem_stage_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_WORDS(LINE_WORDS), .SETS(SETS)
    ) dut (
        .clk(clk), .rst(rst),
        .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
        .i_size(i_size), .i_unsigned(i_unsigned),
        .i_branch(i_branch), .i_alu_zero(i_alu_zero),
        .i_alu_result(i_alu_result), .i_wdata(i_wdata),
        .o_rdata(o_rdata), .o_alu_result(o_alu_result),
        .o_pc_src(o_pc_src), .o_stall(o_stall), .o_hit(o_hit),
        .o_misalign(o_misalign), .o_ram_req(o_ram_req), .o_ram_we(o_ram_we),
        .o_ram_addr(o_ram_addr), .o_ram_wdata(o_ram_wdata),
        .o_ram_wstrb(o_ram_wstrb), .i_ram_ready(i_ram_ready),
        .i_ram_rline(i_ram_rline)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic setReq(input logic rd, input logic wr, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
        i_mem_read   = rd;
        i_mem_write  = wr;
        i_size       = size;
        i_unsigned   = uns;
        i_alu_result = addr;
        i_wdata      = wdata;
        i_ram_ready  = 1'b0;
    endtask

    // Runs from the current cycle until o_stall drops; returns the stalled-cycle
    // count. RAM raises ready after waitCycles request cycles without it.
    task automatic runAccess(input int waitCycles, input logic [127:0] line,
                             output int stalls, output bit timedOut);
        int reqSeen = 0;
        stalls   = 0;
        timedOut = 1'b1;
        for (int c = 0; c < 64; c++) begin
            #1;
            if (o_ram_req) begin
                if (reqSeen == waitCycles) begin
                    i_ram_ready = 1'b1;
                    i_ram_rline = line;
                end
                reqSeen++;
            end
            #1;
            if (!o_stall) begin
                timedOut = 1'b0;
                break;
            end
            stalls++;
            check("pcSrcWhileStalled", 64'(o_pc_src), 64'd0);
            @(negedge clk);
            i_ram_ready = 1'b0;
        end
    endtask

    localparam logic [127:0] LINE_A = {32'h4, 32'h3, 32'h2, 32'h1};
    localparam logic [127:0] LINE_B = {32'h44, 32'h33, 32'h22, 32'h11};

    initial begin
        int stalls;
        bit tmo;

        rst = 1'b1;
        i_branch = 1'b0;
        i_alu_zero = 1'b0;
        i_ram_rline = '0;
        setReq(0, 0, SZ_WORD_C(), 0, 32'h0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("resetStall",  64'(o_stall),     64'd0);
        check("resetReq",    64'(o_ram_req),   64'd0);
        check("resetWe",     64'(o_ram_we),    64'd0);
        check("resetHit",    64'(o_hit),       64'd0);
        check("resetMisal",  64'(o_misalign),  64'd0);
        check("resetWstrb",  64'(o_ram_wstrb), 64'd0);

        i_branch = 1'b1;
        i_alu_zero = 1'b1;

        // Load miss at 0x100, ready after 3 wait cycles
        @(negedge clk);
        setReq(1, 0, 2'd2, 0, 32'h100, 32'h0);
        #1;
        check("fillAddrIdle", 64'(o_ram_req), 64'd0);
        @(negedge clk);
        #1;
        check("fillReq",     64'(o_ram_req),  64'd1);
        check("fillWe",      64'(o_ram_we),   64'd0);
        check("fillAddr",    64'(o_ram_addr), 64'h100);
        runAccess(3, LINE_A, stalls, tmo);
        check("missTimeout", 64'(tmo),    64'd0);
        check("missStalls",  64'(stalls + 1), 64'd5);
        check("missRdata",   64'(o_rdata), 64'h1);
        check("missHitAfter",64'(o_hit),   64'd1);

        // Reload 0x104: hit
        @(negedge clk);
        setReq(1, 0, 2'd2, 0, 32'h104, 32'h0);
        #1;
        check("hitStall",  64'(o_stall),   64'd0);
        check("hitFlag",   64'(o_hit),     64'd1);
        check("hitRdata",  64'(o_rdata),   64'h2);
        check("hitPcSrc",  64'(o_pc_src),  64'd1);
        check("aluPass",   64'(o_alu_result), 64'h104);

        // Store word to cached 0x108, ready immediately
        @(negedge clk);
        setReq(0, 1, 2'd2, 0, 32'h108, 32'hDEADBEEF);
        runAccess(0, LINE_A, stalls, tmo);
        check("stWTimeout", 64'(tmo),         64'd0);
        check("stWStalls",  64'(stalls),      64'd1);
        check("stWReq",     64'(o_ram_req),   64'd1);
        check("stWWe",      64'(o_ram_we),    64'd1);
        check("stWStrb",    64'(o_ram_wstrb), 64'hF);
        check("stWData",    64'(o_ram_wdata), 64'hDEADBEEF);
        check("stWAddr",    64'(o_ram_addr),  64'h108);

        @(negedge clk);
        setReq(1, 0, 2'd2, 0, 32'h108, 32'h0);
        #1;
        check("ldAfterStHit",  64'(o_hit),   64'd1);
        check("ldAfterStData", 64'(o_rdata), 64'hDEADBEEF);

        // Store byte 0x80 to 0x10B
        @(negedge clk);
        setReq(0, 1, 2'd0, 0, 32'h10B, 32'h80);
        runAccess(0, LINE_A, stalls, tmo);
        check("stBStalls", 64'(stalls),      64'd1);
        check("stBStrb",   64'(o_ram_wstrb), 64'h8);
        check("stBData",   64'(o_ram_wdata), 64'h80000000);
        check("stBAddr",   64'(o_ram_addr),  64'h108);

        @(negedge clk);
        setReq(1, 0, 2'd0, 0, 32'h10B, 32'h0);
        #1;
        check("ldBSigned",   64'(o_rdata), 64'hFFFFFF80);
        @(negedge clk);
        setReq(1, 0, 2'd0, 1, 32'h10B, 32'h0);
        #1;
        check("ldBUnsigned", 64'(o_rdata), 64'h00000080);
        @(negedge clk);
        setReq(1, 0, 2'd1, 0, 32'h10A, 32'h0);
        #1;
        check("ldHSigned",   64'(o_rdata), 64'hFFFF80AD);
        @(negedge clk);
        setReq(1, 0, 2'd2, 0, 32'h108, 32'h0);
        #1;
        check("ldWMerged",   64'(o_rdata), 64'h80ADBEEF);

        // Misaligned accesses
        @(negedge clk);
        setReq(1, 0, 2'd1, 0, 32'h101, 32'h0);
        #1;
        check("misHalf",      64'(o_misalign), 64'd1);
        check("misHalfStall", 64'(o_stall),    64'd0);
        check("misHalfReq",   64'(o_ram_req),  64'd0);
        check("misHalfHit",   64'(o_hit),      64'd0);
        @(negedge clk);
        setReq(0, 1, 2'd2, 0, 32'h102, 32'h1234);
        #1;
        check("misWord",      64'(o_misalign), 64'd1);
        check("misWordStall", 64'(o_stall),    64'd0);
        @(negedge clk);
        #1;
        check("misWordNoReq", 64'(o_ram_req),  64'd0);

        // Store miss to 0x200 with 2 wait cycles, then load 0x200 misses
        @(negedge clk);
        setReq(0, 1, 2'd2, 0, 32'h200, 32'hCAFEF00D);
        runAccess(2, LINE_A, stalls, tmo);
        check("stMissStalls", 64'(stalls), 64'd3);
        check("stMissAddr",   64'(o_ram_addr), 64'h200);
        @(negedge clk);
        setReq(1, 0, 2'd2, 0, 32'h200, 32'h0);
        #1;
        check("noAllocMiss",  64'(o_stall), 64'd1);
        check("noAllocHit",   64'(o_hit),   64'd0);
        runAccess(0, LINE_B, stalls, tmo);
        check("fill200Stalls", 64'(stalls),  64'd2);
        check("fill200Rdata",  64'(o_rdata), 64'h11);

        // Refill 0x100 line, then reset during a fill of 0x310
        @(negedge clk);
        setReq(1, 0, 2'd2, 0, 32'h100, 32'h0);
        runAccess(1, LINE_A, stalls, tmo);
        check("refillStalls", 64'(stalls), 64'd3);
        check("refillRdata",  64'(o_rdata), 64'h1);
        @(negedge clk);
        setReq(1, 0, 2'd2, 0, 32'h310, 32'h0);
        #1;
        check("miss310", 64'(o_stall), 64'd1);
        @(negedge clk);
        #1;
        check("fill310Req",  64'(o_ram_req),  64'd1);
        check("fill310Addr", 64'(o_ram_addr), 64'h310);
        #1;
        rst = 1'b1;
        #1;
        check("rstDropsReq", 64'(o_ram_req), 64'd0);
        check("rstDropsWe",  64'(o_ram_we),  64'd0);
        @(negedge clk);
        rst = 1'b0;
        setReq(0, 0, 2'd2, 0, 32'h0, 32'h0);
        i_ram_ready = 1'b1;
        #1;
        check("lateReadyReq",   64'(o_ram_req), 64'd0);
        check("lateReadyStall", 64'(o_stall),   64'd0);
        @(negedge clk);
        setReq(1, 0, 2'd2, 0, 32'h100, 32'h0);
        #1;
        check("postRstMiss", 64'(o_stall), 64'd1);
        check("postRstHit",  64'(o_hit),   64'd0);
        runAccess(0, LINE_A, stalls, tmo);
        check("postRstStalls", 64'(stalls),  64'd2);
        check("postRstRdata",  64'(o_rdata), 64'h1);

        @(negedge clk);
        setReq(0, 0, 2'd2, 0, 32'h0, 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    function automatic logic [1:0] SZ_WORD_C();
        return 2'd2;
    endfunction

endmodule
